// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert jump controller.
// The optional fall/respawn behaviour is enabled by defining QBERT_FALL_EN.
package qbert_pkg;

  localparam int unsigned CoordW = 13;

  typedef logic signed [CoordW-1:0] coord_t;

  typedef enum logic [1:0] {
    BAS_GAUCHE  = 2'd0,
    BAS_DROITE  = 2'd1,
    HAUT_GAUCHE = 2'd2,
    HAUT_DROITE = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StJump = 2'd1,
    StFall = 2'd2
  } state_t;

  // Arc lift factor: rises then falls symmetrically over the jump.
  function automatic coord_t arc_lift(input coord_t k, input coord_t n);
    coord_t rem;
    rem = n - k;
    return (k < rem) ? k : rem;
  endfunction

endpackage

// File: rtl/qbert_hop_calc.sv
// Combinational hop target: next cube, legality on the pyramid and signed anchor steps.
module qbert_hop_calc
  import qbert_pkg::*;
#(
  parameter int unsigned ROWS = 7
) (
  input  logic [1:0]         dir,
  input  logic [2:0]         row,
  input  logic [2:0]         col,
  input  logic [10:0]        xdiag,
  input  logic [9:0]         ydiag,
  output logic [2:0]         trow,
  output logic [2:0]         tcol,
  output logic               legal,
  output logic signed [12:0] dx,
  output logic signed [12:0] dy
);

  localparam logic signed [3:0] RowsS = 4'(ROWS);

  logic signed [3:0] r_s, c_s, tr_s, tc_s;
  coord_t            dx_mag, dy_mag;

  always_comb begin
    r_s    = signed'({1'b0, row});
    c_s    = signed'({1'b0, col});
    dx_mag = coord_t'({2'b00, xdiag}) + coord_t'({3'b000, xdiag[10:1]});
    dy_mag = coord_t'({3'b000, ydiag});
    tr_s   = r_s;
    tc_s   = c_s;
    dx     = dx_mag;
    dy     = dy_mag;
    unique case (dir_t'(dir))
      BAS_GAUCHE: begin
        tr_s = r_s + 4'sd1;
        dy   = -dy_mag;
      end
      BAS_DROITE: begin
        tr_s = r_s + 4'sd1;
        tc_s = c_s + 4'sd1;
      end
      HAUT_GAUCHE: begin
        tr_s = r_s - 4'sd1;
        tc_s = c_s - 4'sd1;
        dx   = -dx_mag;
        dy   = -dy_mag;
      end
      HAUT_DROITE: begin
        tr_s = r_s - 4'sd1;
        dx   = -dx_mag;
      end
    endcase
    legal = (tr_s >= 4'sd0) && (tr_s < RowsS) && (tc_s >= 4'sd0) && (tc_s <= tr_s);
    trow  = tr_s[2:0];
    tcol  = tc_s[2:0];
  end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert hop sequencer: accepts direction requests and animates the sprite anchor per frame.
// Define QBERT_FALL_EN to animate illegal hops off the pyramid followed by a fall and respawn.
module qbert_jump_ctrl
  import qbert_pkg::*;
#(
  parameter int unsigned ROWS        = 7,
  parameter int unsigned JUMP_LOG2   = 3,
  parameter int unsigned ARC_STEP    = 4,
  parameter logic [10:0] X_START     = 11'd60,
  parameter logic [9:0]  Y_START     = 10'd240,
  parameter int unsigned FALL_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        req_valid,
  input  logic [1:0]  req_dir,
  output logic        req_ready,
  input  logic [10:0] XDIAG_DEMI,
  input  logic [9:0]  YDIAG_DEMI,
  output logic [10:0] x0,
  output logic [9:0]  y0,
  output logic [1:0]  orient,
  output logic        qbert_jump,
  output logic [2:0]  row,
  output logic [2:0]  col,
  output logic        landed,
  output logic        fell
);

  localparam int unsigned          N       = 1 << JUMP_LOG2;
  localparam logic [JUMP_LOG2-1:0] KLast   = '1;
  localparam coord_t               NCoord  = coord_t'(N);
  localparam coord_t               ArcStep = coord_t'(ARC_STEP);

  state_t               state_q, state_d;
  logic [JUMP_LOG2-1:0] k_q, k_d;
  coord_t               xs_q, xs_d, ys_q, ys_d, dx_q, dx_d, dy_q, dy_d;
  logic [10:0]          tx_q, tx_d, x0_q, x0_d;
  logic [9:0]           ty_q, ty_d, y0_q, y0_d;
  logic [2:0]           trow_q, trow_d, tcol_q, tcol_d, row_q, row_d, col_q, col_d;
  logic [1:0]           orient_q, orient_d;
  logic                 landed_q, landed_d;

  logic [2:0]           hop_row, hop_col;
  logic                 hop_legal, hop_go;
  logic signed [12:0]   hop_dx, hop_dy;
  coord_t               x_cur, y_cur, k_s, x_step, y_step;
  logic [JUMP_LOG2-1:0] k_inc;

  qbert_hop_calc #(
    .ROWS (ROWS)
  ) u_hop_calc (
    .dir   (req_dir),
    .row   (row_q),
    .col   (col_q),
    .xdiag (XDIAG_DEMI),
    .ydiag (YDIAG_DEMI),
    .trow  (hop_row),
    .tcol  (hop_col),
    .legal (hop_legal),
    .dx    (hop_dx),
    .dy    (hop_dy)
  );

`ifdef QBERT_FALL_EN
  localparam int unsigned FallW    = (FALL_FRAMES > 1) ? $clog2(FALL_FRAMES) : 1;
  localparam logic [FallW-1:0] FallLast = FallW'(FALL_FRAMES - 1);

  logic [FallW-1:0] fc_q, fc_d;
  logic             legal_q, legal_d, fell_q, fell_d;

  // Illegal hops still fly; legality decides what happens at the end of the arc.
  assign hop_go = 1'b1;
  assign fell   = fell_q;
`else
  assign hop_go = hop_legal;
  assign fell   = 1'b0;
`endif

  always_comb begin
    x_cur  = coord_t'({2'b00, x0_q});
    y_cur  = coord_t'({3'b000, y0_q});
    k_inc  = k_q + JUMP_LOG2'(1);
    k_s    = coord_t'(k_inc);
    x_step = xs_q + ((dx_q * k_s) >>> JUMP_LOG2) - ArcStep * arc_lift(k_s, NCoord);
    y_step = ys_q + ((dy_q * k_s) >>> JUMP_LOG2);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    trow_d   = trow_q;
    tcol_d   = tcol_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    row_d    = row_q;
    col_d    = col_q;
    orient_d = orient_q;
    landed_d = 1'b0;
`ifdef QBERT_FALL_EN
    fc_d     = fc_q;
    legal_d  = legal_q;
    fell_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          orient_d = req_dir;
          if (hop_go) begin
            state_d = StJump;
            k_d     = '0;
            xs_d    = x_cur;
            ys_d    = y_cur;
            dx_d    = hop_dx;
            dy_d    = hop_dy;
            tx_d    = 11'(x_cur + hop_dx);
            ty_d    = 10'(y_cur + hop_dy);
            trow_d  = hop_row;
            tcol_d  = hop_col;
`ifdef QBERT_FALL_EN
            legal_d = hop_legal;
`endif
          end
        end
      end
      StJump: begin
        if (frame_tick) begin
          if (k_q == KLast) begin
            // Snap exactly to the target so rounding never accumulates across hops.
            x0_d = tx_q;
            y0_d = ty_q;
`ifdef QBERT_FALL_EN
            if (!legal_q) begin
              state_d = StFall;
              fc_d    = '0;
            end else
`endif
            begin
              row_d    = trow_q;
              col_d    = tcol_q;
              landed_d = 1'b1;
              state_d  = StIdle;
            end
          end else begin
            k_d  = k_inc;
            x0_d = 11'(x_step);
            y0_d = 10'(y_step);
          end
        end
      end
`ifdef QBERT_FALL_EN
      StFall: begin
        if (frame_tick) begin
          if (fc_q == FallLast) begin
            x0_d    = X_START;
            y0_d    = Y_START;
            row_d   = '0;
            col_d   = '0;
            fell_d  = 1'b1;
            state_d = StIdle;
          end else begin
            x0_d = x0_q + 11'(ARC_STEP);
            fc_d = fc_q + FallW'(1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      tx_q     <= X_START;
      ty_q     <= Y_START;
      trow_q   <= '0;
      tcol_q   <= '0;
      x0_q     <= X_START;
      y0_q     <= Y_START;
      row_q    <= '0;
      col_q    <= '0;
      orient_q <= '0;
      landed_q <= 1'b0;
`ifdef QBERT_FALL_EN
      fc_q     <= '0;
      legal_q  <= 1'b0;
      fell_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      trow_q   <= trow_d;
      tcol_q   <= tcol_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      row_q    <= row_d;
      col_q    <= col_d;
      orient_q <= orient_d;
      landed_q <= landed_d;
`ifdef QBERT_FALL_EN
      fc_q     <= fc_d;
      legal_q  <= legal_d;
      fell_q   <= fell_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign qbert_jump = (state_q != StIdle);
  assign x0         = x0_q;
  assign y0         = y0_q;
  assign orient     = orient_q;
  assign row        = row_q;
  assign col        = col_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Randomised bench for qbert_jump_ctrl: pyramid/anchor reference model plus a pulse scoreboard.
module tb_qbert_jump_ctrl;

  logic        clk, reset, frame_tick, req_valid, req_ready;
  logic [1:0]  req_dir, orient;
  logic [10:0] xdiag, x0;
  logic [9:0]  ydiag, y0;
  logic        qbert_jump, landed, fell;
  logic [2:0]  row, col;

  qbert_jump_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .req_ready  (req_ready),
    .XDIAG_DEMI (xdiag),
    .YDIAG_DEMI (ydiag),
    .x0         (x0),
    .y0         (y0),
    .orient     (orient),
    .qbert_jump (qbert_jump),
    .row        (row),
    .col        (col),
    .landed     (landed),
    .fell       (fell)
  );

  typedef struct {
    int x;
    int y;
    int r;
    int c;
    int o;
    bit is_fell;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_landed = 0;
  int   n_landed_exp = 0;

  // Reference model: cube position and anchor in plain integers.
  int m_row, m_col, m_x, m_y;
  int dr[4] = '{1, 1, -1, -1};
  int dc[4] = '{0, 1, -1, 0};
  int sx[4] = '{1, 1, -1, -1};
  int sy[4] = '{-1, 1, -1, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (landed || fell)) begin
      if (landed) n_landed++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got landed=%0d fell=%0d, expected none", landed, fell);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_is_fell", int'(fell), int'(e.is_fell));
        chk("pulse_x0", int'(x0), e.x);
        chk("pulse_y0", int'(y0), e.y);
        chk("pulse_row", int'(row), e.r);
        chk("pulse_col", int'(col), e.c);
        chk("pulse_orient", int'(orient), e.o);
        chk("pulse_req_ready", int'(req_ready), 1);
        chk("pulse_qbert_jump", int'(qbert_jump), 0);
      end
    end
  end

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    m_x   = 60;
    m_y   = 240;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x0", int'(x0), 60);
    chk("rst_y0", int'(y0), 240);
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_orient", int'(orient), 0);
    chk("rst_qbert_jump", int'(qbert_jump), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_landed", int'(landed), 0);
    chk("rst_fell", int'(fell), 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic tick(input bit hold);
    int gap;
    gap = $urandom_range(2, 0);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (hold) req_dir = 2'($urandom_range(3, 0));
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  function automatic int arc_min(input int k);
    return (k < 8 - k) ? k : 8 - k;
  endfunction

  // One hop from the current position; abort_k > 0 asserts reset after that many ticks.
  task automatic do_hop(input int dir, input int xd, input int yd, input bit tick_xfer,
                        input bit hold, input int abort_k);
    int   tr, tc, sdx, sdy, xs, ys, tx, ty;
    bit   legal;
    exp_t e;
    tr    = m_row + dr[dir];
    tc    = m_col + dc[dir];
    legal = (tr >= 0) && (tr < 7) && (tc >= 0) && (tc <= tr);
    sdx   = sx[dir] * (xd + xd / 2);
    sdy   = sy[dir] * yd;
    xs    = m_x;
    ys    = m_y;
    tx    = (xs + sdx) & 'h7FF;
    ty    = (ys + sdy) & 'h3FF;

    req_valid  = 1'b1;
    req_dir    = 2'(dir);
    xdiag      = 11'(xd);
    ydiag      = 10'(yd);
    frame_tick = tick_xfer;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    chk("xfer_orient", int'(orient), dir);
    chk("xfer_x0_still", int'(x0), xs);
`ifndef QBERT_FALL_EN
    if (!legal) begin
      req_valid = 1'b0;
      chk("illegal_qbert_jump", int'(qbert_jump), 0);
      chk("illegal_req_ready", int'(req_ready), 1);
      chk("illegal_y0_still", int'(y0), ys);
      return;
    end
`endif
    req_valid = hold;
    chk("xfer_req_ready", int'(req_ready), 0);
    chk("xfer_qbert_jump", int'(qbert_jump), 1);

    for (int k = 1; k < 8; k++) begin
      tick(hold);
      chk("arc_x0", int'(x0), (xs + ((sdx * k) >>> 3) - 4 * arc_min(k)) & 'h7FF);
      chk("arc_y0", int'(y0), (ys + ((sdy * k) >>> 3)) & 'h3FF);
      if (k == abort_k) begin
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_x0", int'(x0), 60);
        chk("abort_y0", int'(y0), 240);
        chk("abort_req_ready", int'(req_ready), 1);
        chk("abort_qbert_jump", int'(qbert_jump), 0);
        chk("abort_row", int'(row), 0);
        model_reset();
        return;
      end
    end

    if (legal) begin
      e = '{x: tx, y: ty, r: tr, c: tc, o: dir, is_fell: 1'b0};
      exp_q.push_back(e);
      n_landed_exp++;
      m_row = tr;
      m_col = tc;
      m_x   = tx;
      m_y   = ty;
      tick(hold);
      req_valid = 1'b0;
    end else begin
      tick(hold);
      chk("fall_start_x0", int'(x0), tx);
      chk("fall_start_jump", int'(qbert_jump), 1);
      for (int f = 1; f <= 16; f++) begin
        if (f == 16) begin
          e = '{x: 60, y: 240, r: 0, c: 0, o: dir, is_fell: 1'b1};
          exp_q.push_back(e);
        end
        tick(hold);
        if (f < 16) chk("fall_x0", int'(x0), (tx + 4 * f) & 'h7FF);
      end
      req_valid = 1'b0;
      m_row = 0;
      m_col = 0;
      m_x   = 60;
      m_y   = 240;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    req_valid  = 1'b0;
    req_dir    = 2'd0;
    xdiag      = 11'd40;
    ydiag      = 10'd30;
    do_reset();

    // Down-right hop with the transfer coinciding with a frame tick and req_valid held.
    do_hop(1, 40, 30, 1'b1, 1'b1, 0);
    chk("dir1_landed_now", int'(landed), 1);
    chk("dir1_x0", int'(x0), 120);
    chk("dir1_y0", int'(y0), 270);
    chk("dir1_row", int'(row), 1);
    chk("dir1_col", int'(col), 1);
    @(posedge clk);
    #1;
    chk("dir1_landed_once", int'(landed), 0);

    // Up-left off the apex.
    do_reset();
    do_hop(2, 40, 30, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("apex_orient", int'(orient), 2);
    chk("apex_x0", int'(x0), 60);
    chk("apex_row", int'(row), 0);

    // Reset three ticks into a jump.
    do_hop(1, 40, 30, 1'b0, 1'b0, 3);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
      do_hop(int'($urandom_range(3, 0)), int'($urandom_range(60, 8)),
             int'($urandom_range(30, 4)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("landed_count", n_landed, n_landed_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
